// File: rtl/sr_prog_pkg.sv
// Shared definitions for the configuration-chain programmer: register map,
// CTRL/STATUS bit positions, serializer state encoding and word-count helper.
// No logic; pure declarations.
package sr_prog_pkg;

    // Register offsets, selected by addr[3:2]
    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_INDEX = 2'd1;
    localparam logic [1:0] REG_WDATA = 2'd2;
    localparam logic [1:0] REG_RDATA = 2'd3;

    // CTRL write bits
    localparam int CTRL_START     = 0;
    localparam int CTRL_CLR_DONE  = 1;
    // STATUS read bits
    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_WIDTH_LSB = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2
    } ser_state_t;

    // Number of 32-bit bus words needed to hold a chain image
    function automatic int words_for(input int width);
        return (width + 31) / 32;
    endfunction

endpackage

// File: rtl/sr_programmer_if.sv
// Management bus between host and the chain programmer.
// Request held in valid until a one-cycle ready acknowledge.
// rProgData is meaningful only while ready is high.
interface sr_programmer_if;
    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [3:0]  addr;
    logic [31:0] wProgData;
    logic [31:0] rProgData;

    modport master (output valid, wstrb, addr, wProgData,
                    input  ready, rProgData);
    modport slave  (input  valid, wstrb, addr, wProgData,
                    output ready, rProgData);
endinterface

// File: rtl/sr_prog_serializer.sv
// Shifts the image MSB first into the chain and reports captured chain bits.
// Latency: first strobe one cycle after start, then one strobe per SHIFT_DIV cycles.
// No backpressure: the chain accepts a bit on every strobe.
module sr_prog_serializer
    import sr_prog_pkg::*;
#(
    parameter int  WIDTH     = 164,
    parameter int  SHIFT_DIV = 2,
    localparam int KW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] image,
    input  logic             sr_sout,
    output logic             sr_sin,
    output logic             sr_shift,
    output logic             busy,
    output logic             finish,
    output logic             rb_wr,
    output logic [KW-1:0]    rb_idx,
    output logic             rb_bit
);
    localparam int DW = (SHIFT_DIV > 2) ? $clog2(SHIFT_DIV) : 1;

    ser_state_t    state, state_nxt;
    logic [KW-1:0] k, k_nxt;
    logic [DW-1:0] div, div_nxt;
    logic          load_bit;
    logic [KW-1:0] sin_idx;
    logic          sin_nxt;
    logic          shift_nxt;

    // State, counters and registered chain outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            k        <= '0;
            div      <= '0;
            sr_sin   <= 1'b0;
            sr_shift <= 1'b0;
        end else begin
            state    <= state_nxt;
            k        <= k_nxt;
            div      <= div_nxt;
            sr_sin   <= sin_nxt;
            sr_shift <= shift_nxt;
        end
    end

    // Next-state decode; outputs are precomputed so they line up with PULSE
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        div_nxt   = div;
        load_bit  = 1'b0;
        finish    = 1'b0;
        rb_wr     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    k_nxt     = '0;
                    load_bit  = 1'b1;
                    state_nxt = ST_PULSE;
                end
            end
            ST_PULSE: begin
                div_nxt   = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // chain output reflects the strobed bit one cycle after the strobe
                rb_wr = (div == '0);
                if (div == DW'(SHIFT_DIV - 2)) begin
                    if (k == KW'(WIDTH - 1)) begin
                        finish    = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        k_nxt     = k + KW'(1);
                        load_bit  = 1'b1;
                        state_nxt = ST_PULSE;
                    end
                end else begin
                    div_nxt = div + DW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        sin_idx   = KW'(WIDTH - 1) - k_nxt;
        sin_nxt   = load_bit ? image[sin_idx] : sr_sin;
        shift_nxt = (state_nxt == ST_PULSE);
    end

    assign busy   = (state != ST_IDLE);
    assign rb_idx = KW'(WIDTH - 1) - k;
    assign rb_bit = sr_sout;

endmodule

// File: rtl/sr_programmer.sv
// Bus-side programmer: register decode, image/readback storage, status bits.
// Latency: ready one cycle after valid; a run takes WIDTH*SHIFT_DIV cycles.
// Writes to WDATA and start are dropped (but acknowledged) while a run is busy.
module sr_programmer
    import sr_prog_pkg::*;
#(
    parameter int WIDTH     = 164,
    parameter int SHIFT_DIV = 2
) (
    input  logic           clk,
    input  logic           reset,
    sr_programmer_if.slave bus,
    output logic           sr_sin,
    output logic           sr_shift,
    input  logic           sr_sout
);
    localparam int WORDS = words_for(WIDTH);
    localparam int PADW  = WORDS * 32;
    localparam int PW    = $clog2(PADW);
    localparam int KW    = $clog2(WIDTH);

    logic [2:0]       index;
    logic [WIDTH-1:0] image;
    logic [WIDTH-1:0] readback;
    logic             done;
    logic             start_pls;

    logic             busy;
    logic             finish;
    logic             rb_wr;
    logic [KW-1:0]    rb_idx;
    logic             rb_bit;

    logic             accept;
    logic             is_wr;
    logic [1:0]       reg_sel;
    logic             idx_ok;
    logic             busy_any;
    logic [PW-1:0]    word_base;
    logic [PADW-1:0]  img_pad;
    logic [PADW-1:0]  rb_pad;
    logic [PADW-1:0]  img_wr;
    logic [31:0]      rd_word;
    logic             unused_ok;

    assign accept    = bus.valid && !bus.ready;
    assign is_wr     = |bus.wstrb;
    assign reg_sel   = bus.addr[3:2];
    assign idx_ok    = (int'(index) < WORDS);
    assign busy_any  = busy || start_pls;
    assign word_base = PW'({index, 5'b0});
    assign img_pad   = PADW'(image);
    assign rb_pad    = PADW'(readback);
    assign unused_ok = ^bus.addr[1:0];

    // Byte-masked merge of the bus word into the image at INDEX
    always_comb begin
        img_wr = img_pad;
        if (idx_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) begin
                    img_wr[word_base + PW'(b * 8) +: 8] = bus.wProgData[b*8 +: 8];
                end
            end
        end
    end

    // Read mux; out-of-range INDEX reads as zero
    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_CTRL: begin
                rd_word[STAT_WIDTH_LSB +: 16] = 16'(WIDTH);
                rd_word[STAT_DONE]            = done;
                rd_word[STAT_BUSY]            = busy;
            end
            REG_INDEX: rd_word = {29'b0, index};
            REG_WDATA: if (idx_ok) rd_word = img_pad[word_base +: 32];
            REG_RDATA: if (idx_ok) rd_word = rb_pad[word_base +: 32];
            default:   rd_word = '0;
        endcase
    end

    // One-cycle acknowledge with registered read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ready     <= 1'b0;
            bus.rProgData <= '0;
        end else begin
            bus.ready     <= accept;
            bus.rProgData <= (accept && !is_wr) ? rd_word : '0;
        end
    end

    // Register writes, start pulse and done flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index     <= '0;
            image     <= '0;
            done      <= 1'b0;
            start_pls <= 1'b0;
        end else begin
            start_pls <= 1'b0;
            if (accept && is_wr) begin
                case (reg_sel)
                    REG_CTRL: begin
                        if (bus.wProgData[CTRL_START] && !busy_any) begin
                            start_pls <= 1'b1;
                            done      <= 1'b0;
                        end else if (bus.wProgData[CTRL_CLR_DONE]) begin
                            done      <= 1'b0;
                        end
                    end
                    REG_INDEX: index <= bus.wProgData[2:0];
                    REG_WDATA: if (!busy_any && idx_ok) image <= img_wr[WIDTH-1:0];
                    default: ;
                endcase
            end
            // a finishing run cannot coincide with an accepted start
            if (finish) done <= 1'b1;
        end
    end

    // Capture of the chain's previous contents
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readback <= '0;
        end else if (rb_wr) begin
            readback[rb_idx] <= rb_bit;
        end
    end

    sr_prog_serializer #(
        .WIDTH     (WIDTH),
        .SHIFT_DIV (SHIFT_DIV)
    ) u_ser (
        .clk      (clk),
        .reset    (reset),
        .start    (start_pls),
        .image    (image),
        .sr_sout  (sr_sout),
        .sr_sin   (sr_sin),
        .sr_shift (sr_shift),
        .busy     (busy),
        .finish   (finish),
        .rb_wr    (rb_wr),
        .rb_idx   (rb_idx),
        .rb_bit   (rb_bit)
    );

endmodule

// File: tb/tb_sr_programmer.sv
// Bench for sr_programmer: bus master tasks, a behavioural shift-chain model
// driven from sr_shift/sr_sin, and a word-level image/readback model.
module tb_sr_programmer;
    localparam int WIDTH     = 164;
    localparam int SHIFT_DIV = 2;
    localparam int WORDS     = 6;
    localparam logic [3:0] A_CTRL  = 4'h0;
    localparam logic [3:0] A_INDEX = 4'h4;
    localparam logic [3:0] A_WDATA = 4'h8;
    localparam logic [3:0] A_RDATA = 4'hC;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic sr_sin;
    logic sr_shift;
    logic sr_sout = 1'b0;

    sr_programmer_if bus();

    sr_programmer #(.WIDTH(WIDTH), .SHIFT_DIV(SHIFT_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .sr_sin   (sr_sin),
        .sr_shift (sr_shift),
        .sr_sout  (sr_sout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Chain model: each strobe moves the old top bit to the registered output
    // and shifts sr_sin in at bit 0. Owned entirely by this block.
    logic [191:0] chain     = '0;
    logic [191:0] preload_v = '0;
    logic         load_tog  = 1'b0;
    logic         load_seen = 1'b0;
    int           strobes = 0, bad_gap = 0, bad_hold = 0;
    int           first_strobe = -1, last_strobe = 0;
    logic         first_sin = 1'b0, prev_strobe = 1'b0, prev_sin = 1'b0;

    always @(negedge clk) begin
        if (load_tog != load_seen) begin
            load_seen   = load_tog;
            chain       = preload_v;
            strobes     = 0;
            bad_gap     = 0;
            bad_hold    = 0;
            prev_strobe = 1'b0;
        end
        if (prev_strobe && !reset && sr_sin !== prev_sin) bad_hold++;
        prev_strobe = 1'b0;
        if (sr_shift === 1'b1) begin
            if (strobes == 0) begin
                first_strobe = cyc;
                first_sin    = sr_sin;
            end else if (cyc - last_strobe != SHIFT_DIV) begin
                bad_gap++;
            end
            last_strobe  = cyc;
            strobes++;
            sr_sout      = chain[WIDTH-1];
            chain[WIDTH-1:0] = {chain[WIDTH-2:0], sr_sin};
            prev_strobe  = 1'b1;
            prev_sin     = sr_sin;
        end
    end

    int errors = 0;
    int checks = 0;
    int last_ack = 0;
    logic [31:0] img_m [WORDS];
    logic [191:0] pre;
    logic [31:0] rdv;
    int S;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status(input logic b, input logic d);
        return {16'd164, 14'd0, d, b};
    endfunction

    function automatic logic [31:0] keep(input int w, input logic [31:0] v);
        return (w == WORDS - 1) ? (v & 32'h0000_000F) : v;
    endfunction

    task automatic xfer(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd);
        logic got;
        got = 1'b0;
        bus.valid = 1'b1; bus.addr = a; bus.wProgData = d; bus.wstrb = s;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        rd = bus.rProgData;
        last_ack = cyc;
        bus.valid = 1'b0; bus.wstrb = 4'h0;
        chk("bus_ack", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        xfer(a, d, s, dummy);
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        xfer(a, 32'h0, 4'h0, v);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic arm(input logic [191:0] p);
        preload_v = p;
        load_tog  = ~load_tog;
        @(negedge clk); #1;
    endtask

    task automatic load_image();
        for (int w = 0; w < WORDS; w++) begin
            wr(A_INDEX, w, 4'hF);
            wr(A_WDATA, img_m[w], 4'hF);
            img_m[w] = keep(w, img_m[w]);
        end
    endtask

    task automatic check_run(input string tag, input logic [191:0] p);
        chk({tag, "_strobes"}, strobes, 164);
        chk({tag, "_gap"}, bad_gap, 0);
        chk({tag, "_hold"}, bad_hold, 0);
        chk({tag, "_first_sin"}, {31'd0, first_sin}, {31'd0, img_m[5][3]});
        for (int w = 0; w < WORDS; w++) begin
            chk({tag, "_chain"}, chain[w*32 +: 32], img_m[w]);
            wr(A_INDEX, w, 4'hF);
            rd(A_WDATA, rdv);
            chk({tag, "_image"}, rdv, img_m[w]);
            rd(A_RDATA, rdv);
            chk({tag, "_readback"}, rdv, keep(w, p[w*32 +: 32]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid = 1'b0; bus.addr = 4'h0; bus.wstrb = 4'h0; bus.wProgData = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.ready}, 32'd0);
        chk("rst_rdata", bus.rProgData, 32'd0);
        chk("rst_shift", {31'd0, sr_shift}, 32'd0);
        chk("rst_sin", {31'd0, sr_sin}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        rd(A_CTRL, rdv);  chk("rst_status", rdv, 32'h00A4_0000);
        rd(A_INDEX, rdv); chk("rst_index", rdv, 32'd0);

        // Run 1: fixed image, fixed chain preload, done exactly at S+329
        img_m[0] = 32'h1111_1111; img_m[1] = 32'h2222_2222; img_m[2] = 32'h3333_3333;
        img_m[3] = 32'h4444_4444; img_m[4] = 32'h5555_5555; img_m[5] = 32'h0000_000A;
        load_image();
        for (int w = 0; w < WORDS; w++) pre[w*32 +: 32] = (w == 5) ? 32'hA : 32'h5555_5555;
        arm(pre);
        wr(A_CTRL, 32'h1, 4'hF);
        S = last_ack;
        wait_cyc(S + 1 + WIDTH * SHIFT_DIV);
        rd(A_CTRL, rdv); chk("run1_done", rdv, status(1'b0, 1'b1));
        chk("run1_first_strobe", first_strobe, S + 1);
        check_run("run1", pre);
        wr(A_CTRL, 32'h2, 4'hF);
        rd(A_CTRL, rdv); chk("clear_done", rdv, status(1'b0, 1'b0));

        // Run 2: random image/preload, WDATA write and start while busy
        for (int w = 0; w < WORDS; w++) img_m[w] = $urandom;
        load_image();
        for (int w = 0; w < WORDS; w++) pre[w*32 +: 32] = $urandom;
        pre[191:WIDTH] = '0;
        arm(pre);
        wr(A_CTRL, 32'h1, 4'hF);
        S = last_ack;
        wait_cyc(S + 50);
        wr(A_WDATA, 32'hDEAD_BEEF, 4'hF);
        wait_cyc(S + 80);
        wr(A_CTRL, 32'h1, 4'hF);
        wait_cyc(S + WIDTH * SHIFT_DIV);
        rd(A_CTRL, rdv); chk("run2_busy", rdv, status(1'b1, 1'b0));
        wait_cyc(S + 420);
        rd(A_CTRL, rdv); chk("run2_done", rdv, status(1'b0, 1'b1));
        chk("run2_first_strobe", first_strobe, S + 1);
        check_run("run2", pre);

        // Boundaries: out-of-range INDEX, byte mask, RDATA read-only, top-word mask
        wr(A_INDEX, 32'd6, 4'hF);
        wr(A_WDATA, 32'hFFFF_FFFF, 4'hF);
        rd(A_WDATA, rdv); chk("idx6_wdata", rdv, 32'd0);
        rd(A_RDATA, rdv); chk("idx6_rdata", rdv, 32'd0);
        rd(A_INDEX, rdv); chk("idx6_index", rdv, 32'd6);
        wr(A_INDEX, 32'd5, 4'hF);
        rd(A_WDATA, rdv); chk("idx6_nochange", rdv, img_m[5]);
        wr(A_INDEX, 32'd0, 4'hF);
        wr(A_WDATA, 32'hAABB_CCDD, 4'b0010);
        img_m[0][15:8] = 8'hCC;
        rd(A_WDATA, rdv); chk("byte_mask", rdv, img_m[0]);
        wr(A_RDATA, 32'h1234_5678, 4'hF);
        rd(A_RDATA, rdv); chk("rdata_ro", rdv, pre[31:0]);
        wr(A_INDEX, 32'd5, 4'hF);
        wr(A_WDATA, 32'hFFFF_FFFF, 4'hF);
        rd(A_WDATA, rdv); chk("top_word_mask", rdv, 32'h0000_000F);

        // Reset during strobe 50, then a clean restart
        for (int w = 0; w < WORDS; w++) pre[w*32 +: 32] = $urandom;
        pre[191:WIDTH] = '0;
        arm(pre);
        wr(A_CTRL, 32'h1, 4'hF);
        for (int i = 0; i < 400 && strobes < 50; i++) @(negedge clk);
        chk("reach_strobe50", strobes, 50);
        #1 reset = 1'b1;
        #1;
        chk("midrst_shift", {31'd0, sr_shift}, 32'd0);
        chk("midrst_sin", {31'd0, sr_sin}, 32'd0);
        chk("midrst_ready", {31'd0, bus.ready}, 32'd0);
        chk("midrst_rdata", bus.rProgData, 32'd0);
        @(posedge clk); @(negedge clk); #2 reset = 1'b0;
        @(posedge clk); #1;
        rd(A_CTRL, rdv);  chk("midrst_status", rdv, status(1'b0, 1'b0));
        rd(A_INDEX, rdv); chk("midrst_index", rdv, 32'd0);
        for (int w = 0; w < WORDS; w++) img_m[w] = 32'd0;
        for (int w = 0; w < WORDS; w++) pre[w*32 +: 32] = $urandom;
        pre[191:WIDTH] = '0;
        arm(pre);
        wr(A_CTRL, 32'h1, 4'hF);
        S = last_ack;
        wait_cyc(S + 420);
        rd(A_CTRL, rdv); chk("run3_done", rdv, status(1'b0, 1'b1));
        check_run("run3", pre);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
